// File: rtl/rfphoenix_vec_wb_sequencer.sv
// Write-port sequencer for the vector register file: round-robin arbitration between
// functional-unit results and a beat-assembled load, one registered write per cycle.
module rfphoenix_vec_wb_sequencer #(
  parameter int NLANES = 16,
  parameter int LANEW  = 32,
  parameter int NSRC   = 2,
  parameter int NBEATS = 4,
  parameter int TIDW   = 2,
  parameter int RSW    = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NSRC-1:0]                   src_valid,
  output logic [NSRC-1:0]                   src_ready,
  input  logic [NSRC*TIDW-1:0]              src_thread,
  input  logic [NSRC*RSW-1:0]               src_reg,
  input  logic [NSRC*NLANES*4-1:0]          src_mask,
  input  logic [NSRC*NLANES*LANEW-1:0]      src_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [TIDW-1:0]                   ld_thread,
  input  logic [RSW-1:0]                    ld_reg,
  input  logic [$clog2(NBEATS)-1:0]         ld_beat,
  input  logic                              ld_last,
  input  logic [NLANES*4/NBEATS-1:0]        ld_mask,
  input  logic [NLANES*LANEW/NBEATS-1:0]    ld_data,
  output logic                              ld_err,
  output logic                              wr,
  output logic [TIDW-1:0]                   wthread,
  output logic [RSW-1:0]                    wa,
  output logic [NLANES*4-1:0]               wmask,
  output logic [NLANES*LANEW-1:0]           wdata
);

  localparam int MW   = NLANES * 4;
  localparam int DW   = NLANES * LANEW;
  localparam int BMW  = MW / NBEATS;
  localparam int BDW  = DW / NBEATS;
  localparam int BW   = $clog2(NBEATS);
  localparam int NREQ = NSRC + 1;
  localparam int PW   = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PEND
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     exp_q, exp_d;
  logic              merge, load_err, buf_clr;

  logic [TIDW-1:0]   buf_thread;
  logic [RSW-1:0]    buf_reg;
  logic [MW-1:0]     buf_mask;
  logic [DW-1:0]     buf_data;

  logic [PW-1:0]     rr_q;
  logic [NREQ-1:0]   req, grant;
  logic [PW-1:0]     win, idx;
  logic              any;

  logic [TIDW-1:0]   sel_thread;
  logic [RSW-1:0]    sel_reg;
  logic [MW-1:0]     sel_mask;
  logic [DW-1:0]     sel_data;

  // rr_q is always below NREQ, so a single subtraction wraps the rotated index.
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  assign req       = {state_q == S_PEND, src_valid};
  assign src_ready = grant[NSRC-1:0];

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = wrap(rr_q, i);
      if (!any && req[idx]) begin
        any        = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_thread = buf_thread;
    sel_reg    = buf_reg;
    sel_mask   = buf_mask;
    sel_data   = buf_data;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (grant[s]) begin
        sel_thread = src_thread[s*TIDW +: TIDW];
        sel_reg    = src_reg[s*RSW +: RSW];
        sel_mask   = src_mask[s*MW +: MW];
        sel_data   = src_data[s*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    ld_ready = 1'b0;
    merge    = 1'b0;
    load_err = 1'b0;
    buf_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_beat == '0) begin
            merge   = 1'b1;
            exp_d   = BW'(1);
            state_d = ld_last ? S_PEND : S_COLLECT;
          end else begin
            load_err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_beat == exp_q) begin
            merge = 1'b1;
            exp_d = exp_q + BW'(1);
            if (ld_last || exp_q == BW'(NBEATS - 1)) state_d = S_PEND;
          end else begin
            load_err = 1'b1;
            buf_clr  = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_PEND: begin
        if (grant[NSRC]) begin
          buf_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  // Buffer stays zeroed while idle, so unreceived lane groups always present mask 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_thread <= '0;
      buf_reg    <= '0;
      buf_mask   <= '0;
      buf_data   <= '0;
    end else if (buf_clr) begin
      buf_mask <= '0;
      buf_data <= '0;
    end else if (merge) begin
      if (state_q == S_IDLE) begin
        buf_thread <= ld_thread;
        buf_reg    <= ld_reg;
      end
      for (int unsigned g = 0; g < NBEATS; g++) begin
        if (ld_beat == BW'(g)) begin
          buf_mask[g*BMW +: BMW] <= ld_mask;
          buf_data[g*BDW +: BDW] <= ld_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr      <= 1'b0;
      ld_err  <= 1'b0;
      wthread <= '0;
      wa      <= '0;
      wmask   <= '0;
      wdata   <= '0;
      rr_q    <= '0;
    end else begin
      wr     <= any;
      ld_err <= load_err;
      if (any) begin
        wthread <= sel_thread;
        wa      <= sel_reg;
        wmask   <= sel_mask;
        wdata   <= sel_data;
        rr_q    <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rfphoenix_vec_wb_sequencer.sv
// Bench for rfphoenix_vec_wb_sequencer: directed scenarios plus random traffic,
// all checked against a transaction-level model of arbitration and load assembly.
module tb_rfphoenix_vec_wb_sequencer;

  localparam int NLANES = 16;
  localparam int LANEW  = 32;
  localparam int NSRC   = 2;
  localparam int NBEATS = 4;
  localparam int TIDW   = 2;
  localparam int RSW    = 6;
  localparam int MW     = NLANES * 4;
  localparam int DW     = NLANES * LANEW;
  localparam int BMW    = MW / NBEATS;
  localparam int BDW    = DW / NBEATS;
  localparam int BW     = $clog2(NBEATS);
  localparam int NREQ   = NSRC + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NSRC-1:0]          src_valid;
  logic [NSRC-1:0]          src_ready;
  logic [NSRC*TIDW-1:0]     src_thread;
  logic [NSRC*RSW-1:0]      src_reg;
  logic [NSRC*MW-1:0]       src_mask;
  logic [NSRC*DW-1:0]       src_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [TIDW-1:0]          ld_thread;
  logic [RSW-1:0]           ld_reg;
  logic [BW-1:0]            ld_beat;
  logic                     ld_last;
  logic [BMW-1:0]           ld_mask;
  logic [BDW-1:0]           ld_data;
  logic                     ld_err;
  logic                     wr;
  logic [TIDW-1:0]          wthread;
  logic [RSW-1:0]           wa;
  logic [MW-1:0]            wmask;
  logic [DW-1:0]            wdata;

  always #5 clk = ~clk;

  rfphoenix_vec_wb_sequencer #(
    .NLANES(NLANES), .LANEW(LANEW), .NSRC(NSRC),
    .NBEATS(NBEATS), .TIDW(TIDW), .RSW(RSW)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_thread(src_thread),
    .src_reg(src_reg), .src_mask(src_mask), .src_data(src_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_thread(ld_thread), .ld_reg(ld_reg),
    .ld_beat(ld_beat), .ld_last(ld_last), .ld_mask(ld_mask), .ld_data(ld_data),
    .ld_err(ld_err), .wr(wr), .wthread(wthread), .wa(wa), .wmask(wmask), .wdata(wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: rotating priority pointer plus a per-group load buffer.
  int               m_ptr;
  bit               m_pend;
  int               m_next;
  logic [BMW-1:0]   m_gmask [NBEATS];
  logic [BDW-1:0]   m_gdata [NBEATS];
  logic [TIDW-1:0]  m_thr;
  logic [RSW-1:0]   m_reg;
  bit               e_wr, e_err;
  logic [TIDW-1:0]  e_wthread;
  logic [RSW-1:0]   e_wa;
  logic [MW-1:0]    e_wmask;
  logic [DW-1:0]    e_wdata;
  logic [NSRC-1:0]  obs_ready;
  logic             obs_ld_ready;

  task automatic clear_groups();
    for (int g = 0; g < NBEATS; g++) begin
      m_gmask[g] = '0;
      m_gdata[g] = '0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_next = 0; m_thr = '0; m_reg = '0;
    clear_groups();
    e_wr = 0; e_err = 0; e_wthread = '0; e_wa = '0; e_wmask = '0; e_wdata = '0;
  endtask

  task automatic idle_inputs();
    src_valid = '0; src_thread = '0; src_reg = '0; src_mask = '0; src_data = '0;
    ld_valid = 0; ld_thread = '0; ld_reg = '0; ld_beat = '0; ld_last = 0;
    ld_mask = '0; ld_data = '0;
  endtask

  // Called at posedge+1 with inputs set; checks handshakes, clocks, checks the write port.
  task automatic step();
    int win;
    logic [NSRC-1:0] exp_ready;
    #1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int r;
      bit v;
      r = (m_ptr + k) % NREQ;
      v = (r == NSRC) ? m_pend : src_valid[r];
      if (win < 0 && v) win = r;
    end
    exp_ready = '0;
    if (win >= 0 && win < NSRC) exp_ready[win] = 1'b1;
    obs_ready    = src_ready;
    obs_ld_ready = ld_ready;
    check("src_ready", DW'(src_ready), DW'(exp_ready));
    check("ld_ready", DW'(ld_ready), DW'(!m_pend));

    e_wr = (win >= 0);
    if (win >= 0 && win < NSRC) begin
      e_wthread = src_thread[win*TIDW +: TIDW];
      e_wa      = src_reg[win*RSW +: RSW];
      e_wmask   = src_mask[win*MW +: MW];
      e_wdata   = src_data[win*DW +: DW];
    end else if (win == NSRC) begin
      e_wthread = m_thr;
      e_wa      = m_reg;
      for (int g = 0; g < NBEATS; g++) begin
        e_wmask[g*BMW +: BMW] = m_gmask[g];
        e_wdata[g*BDW +: BDW] = m_gdata[g];
      end
    end

    e_err = 0;
    if (!m_pend && ld_valid) begin
      if (int'(ld_beat) == m_next) begin
        if (m_next == 0) begin
          m_thr = ld_thread;
          m_reg = ld_reg;
        end
        m_gmask[m_next] = ld_mask;
        m_gdata[m_next] = ld_data;
        m_next++;
        if (ld_last || m_next == NBEATS) m_pend = 1;
      end else begin
        e_err = 1;
        clear_groups();
        m_next = 0;
      end
    end
    if (win == NSRC) begin
      m_pend = 0;
      m_next = 0;
      clear_groups();
    end
    if (win >= 0) m_ptr = (win + 1) % NREQ;

    @(posedge clk);
    #1;
    check("wr", DW'(wr), DW'(e_wr));
    check("ld_err", DW'(ld_err), DW'(e_err));
    check("wthread", DW'(wthread), DW'(e_wthread));
    check("wa", DW'(wa), DW'(e_wa));
    check("wmask", DW'(wmask), DW'(e_wmask));
    check("wdata", wdata, e_wdata);
  endtask

  task automatic do_reset();
    idle_inputs();
    #2;
    rst = 0;
    #1;
    model_reset();
    check("rst_wr", DW'(wr), '0);
    check("rst_ld_err", DW'(ld_err), '0);
    check("rst_wthread", DW'(wthread), '0);
    check("rst_wa", DW'(wa), '0);
    check("rst_wmask", DW'(wmask), '0);
    check("rst_wdata", wdata, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic send_beat(input int b, input bit last, input logic [TIDW-1:0] t,
                           input logic [RSW-1:0] r, input logic [BMW-1:0] m);
    ld_valid = 1; ld_beat = BW'(b); ld_last = last; ld_thread = t; ld_reg = r;
    ld_mask = m;
    for (int i = 0; i < BDW / 32; i++) ld_data[i*32 +: 32] = $urandom;
    step();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic rand_inputs();
    src_valid  = NSRC'($urandom);
    src_thread = (NSRC*TIDW)'($urandom);
    src_reg    = (NSRC*RSW)'($urandom);
    for (int i = 0; i < NSRC * MW / 32; i++) src_mask[i*32 +: 32] = $urandom;
    for (int i = 0; i < NSRC * DW / 32; i++) src_data[i*32 +: 32] = $urandom;
    ld_valid  = ($urandom_range(0, 3) != 0);
    ld_beat   = ($urandom_range(0, 9) == 0) ? BW'($urandom) : BW'(m_next);
    ld_last   = ($urandom_range(0, 3) == 0);
    ld_thread = TIDW'($urandom);
    ld_reg    = RSW'($urandom);
    ld_mask   = ($urandom_range(0, 7) == 0) ? '0 : BMW'($urandom);
    for (int i = 0; i < BDW / 32; i++) ld_data[i*32 +: 32] = $urandom;
  endtask

  logic [DW-1:0] lane_vec;

  initial begin
    idle_inputs();
    model_reset();
    #1;

    // Single FU write: lane k carries k.
    do_reset();
    for (int k = 0; k < NLANES; k++) lane_vec[k*LANEW +: LANEW] = LANEW'(k);
    src_valid = 2'b01; src_reg[RSW-1:0] = 6'd5; src_thread[TIDW-1:0] = 2'd1;
    src_mask[MW-1:0] = '1; src_data[DW-1:0] = lane_vec;
    step();
    check("fu0_ready", DW'(obs_ready), DW'(2'b01));
    check("fu0_wr", DW'(wr), DW'(1'b1));
    check("fu0_wa", DW'(wa), DW'(6'd5));
    check("fu0_wthread", DW'(wthread), DW'(2'd1));
    check("fu0_wdata", wdata, lane_vec);
    idle_inputs();

    // Both FUs held valid: strict alternation, a write every cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src_valid = 2'b11;
      src_reg = (NSRC*RSW)'($urandom);
      for (int i = 0; i < NSRC * DW / 32; i++) src_data[i*32 +: 32] = $urandom;
      step();
      check("rr_grant", DW'(obs_ready), DW'((k % 2 == 0) ? 2'b01 : 2'b10));
      check("rr_wr", DW'(wr), DW'(1'b1));
    end
    idle_inputs();

    // Full four-beat load.
    do_reset();
    for (int b = 0; b < NBEATS; b++) send_beat(b, b == NBEATS - 1, 2'd2, 6'd9, '1);
    step();
    check("ld_full_ready_low", DW'(obs_ld_ready), DW'(1'b0));
    check("ld_full_wr", DW'(wr), DW'(1'b1));
    check("ld_full_wmask", DW'(wmask), DW'(64'hFFFF_FFFF_FFFF_FFFF));
    check("ld_full_wa", DW'(wa), DW'(6'd9));
    check("ld_full_wthread", DW'(wthread), DW'(2'd2));
    step();
    check("ld_full_ready_back", DW'(obs_ld_ready), DW'(1'b1));

    // Short load ending on beat 1.
    send_beat(0, 0, 2'd3, 6'd17, '1);
    send_beat(1, 1, 2'd3, 6'd17, '1);
    step();
    check("ld_short_wr", DW'(wr), DW'(1'b1));
    check("ld_short_wmask", DW'(wmask), DW'(64'h0000_0000_FFFF_FFFF));

    // Out-of-sequence beat aborts, then a clean load still completes.
    send_beat(0, 0, 2'd1, 6'd3, '1);
    send_beat(2, 0, 2'd1, 6'd3, '1);
    check("seq_err_pulse", DW'(ld_err), DW'(1'b1));
    check("seq_err_nowr", DW'(wr), DW'(1'b0));
    for (int b = 0; b < NBEATS; b++) send_beat(b, 0, 2'd1, 6'd4, BMW'($urandom));
    step();
    check("seq_recover_wr", DW'(wr), DW'(1'b1));
    check("seq_recover_wa", DW'(wa), DW'(6'd4));

    // Reset in the middle of a load with an FU request outstanding.
    do_reset();
    send_beat(0, 0, 2'd2, 6'd7, '1);
    send_beat(1, 0, 2'd2, 6'd7, '1);
    src_valid = 2'b01; src_reg = '1; src_mask = '1;
    #2;
    rst = 0;
    #1;
    check("midrst_wr", DW'(wr), '0);
    check("midrst_wmask", DW'(wmask), '0);
    check("midrst_wdata", wdata, '0);
    check("midrst_wa", DW'(wa), '0);
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1;
    step();
    check("midrst_nowr", DW'(wr), DW'(1'b0));
    send_beat(1, 0, 2'd2, 6'd7, '1);
    check("midrst_beat1_err", DW'(ld_err), DW'(1'b1));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
